// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, debug command codes
// and the state-class helper used by the enable decode.
package pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_STEP  = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_CLEAR = 2'd3
    } seq_cmd_e;

    // States in which the front end (PC, IF/ID) is allowed to advance
    function automatic logic state_advances(input seq_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard.sv
// Load-use hazard compare: the load in EX writes a register the instruction in ID reads.
module hazard_detect_unit #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_idex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_idex_rt,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs,
    input  logic [REG_ADDR_W-1:0] i_ifid_rt,
    output logic                  o_hazard
);

    // $zero is never a real dependency
    assign o_hazard = i_idex_mem_read && (i_idex_rt != '0) &&
                      ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: debug run/step/stop/clear FSM, HALT drain, load-use stall,
// taken-branch IF/ID flush and a saturating count of pipeline-advance cycles.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned REG_ADDR_W   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    input  logic [1:0]            i_cmd,
    output logic                  o_cmd_ready,
    input  logic                  i_halt_inst,
    input  logic                  i_branch_taken,
    input  logic                  i_idex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_idex_rt,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs,
    input  logic [REG_ADDR_W-1:0] i_ifid_rt,
    output logic                  o_pc_enable,
    output logic                  o_ifid_enable,
    output logic                  o_ifid_flush,
    output logic                  o_idex_bubble,
    output logic                  o_pipe_enable,
    output logic                  o_pipe_clear,
    output logic                  o_step_done,
    output logic [1:0]            o_state,
    output logic [CNT_W-1:0]      o_cycle_count
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    seq_state_e    state, state_nxt;
    seq_cmd_e      cmd;
    logic          hazard;
    logic          cmd_fire;
    logic          halted, halted_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          step_done_nxt, pipe_clear_nxt, count_clear;

    hazard_detect_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .i_idex_mem_read(i_idex_mem_read),
        .i_idex_rt      (i_idex_rt),
        .i_ifid_rs      (i_ifid_rs),
        .i_ifid_rt      (i_ifid_rt),
        .o_hazard       (hazard)
    );

    assign cmd         = seq_cmd_e'(i_cmd);
    assign o_cmd_ready = (state == ST_IDLE) || (state == ST_RUN);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign o_state     = state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            halted        <= 1'b0;
            drain_cnt     <= '0;
            o_step_done   <= 1'b0;
            o_pipe_clear  <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            state        <= state_nxt;
            halted       <= halted_nxt;
            drain_cnt    <= drain_cnt_nxt;
            o_step_done  <= step_done_nxt;
            o_pipe_clear <= pipe_clear_nxt;
            if (count_clear)
                o_cycle_count <= '0;
            else if (o_pipe_enable && (o_cycle_count != '1))
                o_cycle_count <= o_cycle_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt      = state;
        halted_nxt     = halted;
        drain_cnt_nxt  = drain_cnt;
        step_done_nxt  = 1'b0;
        pipe_clear_nxt = 1'b0;
        count_clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd)
                        CMD_RUN:  state_nxt = ST_RUN;
                        CMD_STEP: if (!halted) state_nxt = ST_STEP;
                        CMD_CLEAR: begin
                            pipe_clear_nxt = 1'b1;
                            count_clear    = 1'b1;
                            halted_nxt     = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // STOP beats a HALT seen in the same cycle; a stalled HALT waits
                if (cmd_fire && (cmd == CMD_STOP)) begin
                    state_nxt = ST_IDLE;
                end else if (i_halt_inst && !hazard) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            ST_STEP: begin
                state_nxt     = ST_IDLE;
                step_done_nxt = 1'b1;
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt  = ST_IDLE;
                    halted_nxt = 1'b1;
                end else begin
                    drain_cnt_nxt = drain_cnt - DW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pc_enable   = 1'b0;
        o_ifid_enable = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_pipe_enable = 1'b0;
        if (state_advances(state)) begin
            o_pipe_enable = 1'b1;
            if (hazard) begin
                o_idex_bubble = 1'b1;
            end else begin
                o_pc_enable   = 1'b1;
                o_ifid_enable = 1'b1;
                o_ifid_flush  = i_branch_taken && !i_halt_inst;
            end
        end else if (state == ST_DRAIN) begin
            o_pipe_enable = 1'b1;
            o_ifid_flush  = (drain_cnt == DRAIN_LOAD);
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboarded bench for pipeline_sequencer: directed scenarios then random traffic,
// each cycle's expected outputs produced by a cycle-level behavioural model.
module tb_pipeline_sequencer;

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DRAIN  = 4;
    localparam int unsigned CNTMAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_cmd_valid = 1'b0;
    logic [1:0]       i_cmd = '0;
    logic             i_halt_inst = 1'b0, i_branch_taken = 1'b0, i_idex_mem_read = 1'b0;
    logic [4:0]       i_idex_rt = '0, i_ifid_rs = '0, i_ifid_rt = '0;
    logic             o_cmd_ready, o_pc_enable, o_ifid_enable, o_ifid_flush;
    logic             o_idex_bubble, o_pipe_enable, o_pipe_clear, o_step_done;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_cycle_count;

    pipeline_sequencer #(
        .DRAIN_CYCLES(DRAIN),
        .CNT_W       (CNT_W),
        .REG_ADDR_W  (5)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd          (i_cmd),
        .o_cmd_ready    (o_cmd_ready),
        .i_halt_inst    (i_halt_inst),
        .i_branch_taken (i_branch_taken),
        .i_idex_mem_read(i_idex_mem_read),
        .i_idex_rt      (i_idex_rt),
        .i_ifid_rs      (i_ifid_rs),
        .i_ifid_rt      (i_ifid_rt),
        .o_pc_enable    (o_pc_enable),
        .o_ifid_enable  (o_ifid_enable),
        .o_ifid_flush   (o_ifid_flush),
        .o_idex_bubble  (o_idex_bubble),
        .o_pipe_enable  (o_pipe_enable),
        .o_pipe_clear   (o_pipe_clear),
        .o_step_done    (o_step_done),
        .o_state        (o_state),
        .o_cycle_count  (o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          ready, pc, ifid, flush, bubble, pipe, clr, sd;
        int unsigned st, cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Model: mode 0 idle, 1 running, 2 single step, 3 draining
    int unsigned m_mode, m_left, m_count;
    bit          m_halted, m_sd_pend, m_clr_pend;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_count = 0;
        m_halted = 0; m_sd_pend = 0; m_clr_pend = 0;
    endtask

    task automatic cyc(input bit rst, input bit v, input int c, input bit h, input bit b,
                       input bit mr, input int irt, input int rs, input int rt);
        exp_t e;
        bit   hz, adv, fire;
        @(negedge i_clk);
        i_reset = rst; i_cmd_valid = v; i_cmd = 2'(c); i_halt_inst = h;
        i_branch_taken = b; i_idex_mem_read = mr;
        i_idex_rt = 5'(irt); i_ifid_rs = 5'(rs); i_ifid_rt = 5'(rt);
        if (rst) begin
            model_reset();
            return;
        end
        hz       = mr && (irt != 0) && (irt == rs || irt == rt);
        adv      = (m_mode == 1) || (m_mode == 2);
        e.ready  = (m_mode <= 1);
        e.pc     = adv && !hz;
        e.ifid   = adv && !hz;
        e.bubble = adv && hz;
        e.pipe   = adv || (m_mode == 3);
        e.flush  = (adv && !hz && b && !h) || (m_mode == 3 && m_left == DRAIN);
        e.sd     = m_sd_pend;
        e.clr    = m_clr_pend;
        e.st     = m_mode;
        e.cnt    = m_count;
        sb.push_back(e);

        fire = v && e.ready;
        m_sd_pend = 0; m_clr_pend = 0;
        if (e.pipe && m_count < CNTMAX) m_count++;
        case (m_mode)
            0: if (fire) begin
                if (c == 0) m_mode = 1;
                else if (c == 1 && !m_halted) m_mode = 2;
                else if (c == 3) begin m_clr_pend = 1; m_count = 0; m_halted = 0; end
            end
            1: if (fire && c == 2) m_mode = 0;
               else if (h && !hz) begin m_mode = 3; m_left = DRAIN; end
            2: begin m_mode = 0; m_sd_pend = 1; end
            default: begin
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_halted = 1; end
            end
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cmd(input int c);
        cyc(0, 1, c, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cmd_ready",   32'(o_cmd_ready),   32'(e.ready));
                chk("pc_enable",   32'(o_pc_enable),   32'(e.pc));
                chk("ifid_enable", 32'(o_ifid_enable), 32'(e.ifid));
                chk("ifid_flush",  32'(o_ifid_flush),  32'(e.flush));
                chk("idex_bubble", 32'(o_idex_bubble), 32'(e.bubble));
                chk("pipe_enable", 32'(o_pipe_enable), 32'(e.pipe));
                chk("pipe_clear",  32'(o_pipe_clear),  32'(e.clr));
                chk("step_done",   32'(o_step_done),   32'(e.sd));
                chk("state",       32'(o_state),       e.st);
                chk("cycle_count", 32'(o_cycle_count), e.cnt);
            end
        end
    end

    initial begin : stimulus
        int waitc;
        model_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Free run, load-use stall and its $zero exception, branch flush, branch under stall
        cmd(0);
        idle(10);
        cyc(0, 0, 0, 0, 0, 1, 8, 8, 3);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 8, 8, 8);
        cyc(0, 0, 0, 0, 1, 1, 9, 2, 9);
        cyc(0, 0, 0, 1, 0, 1, 6, 6, 0);
        // HALT drain, rejected STEP while halted, CLEAR, then one STEP
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle(DRAIN + 1);
        cmd(1);
        idle(2);
        cmd(3);
        idle(2);
        cmd(1);
        idle(3);
        // STOP in the same cycle as HALT
        cmd(0);
        idle(2);
        cyc(0, 1, 2, 1, 0, 0, 0, 0, 0);
        idle(2);
        // Reset in the second DRAIN cycle
        cmd(0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Reset in the STEP cycle
        cmd(1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 3)),
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
        end
        idle(1);

        waitc = 0;
        while (sb.size() > 0 && waitc < 20) begin
            @(negedge i_clk);
            waitc++;
        end
        #5;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
